// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath width, reserved NOP encoding and a
// pointer-width helper used to size queue pointers and counters.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    // Canonical ADDI x0,x0,0. Reserved; the fetch queue itself emits 0 when idle.
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    // Bits needed to index n distinct values; never less than 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/instr_ram_dp.sv
// Dual-port synchronous instruction RAM (inferred block RAM, no data reset).
//   Port A: read-only, registered output, read enabled by ena.
//   Port B: registered read every cycle plus byte-masked write, read-first.
// Ports:
//   clk                    clock
//   ena, addra, douta      fetch read port
//   addrb, dinb, web, doutb debug read/write port
module instr_ram_dp #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 12
) (
    input  logic              clk,
    input  logic              ena,
    input  logic [AW-1:0]     addra,
    output logic [XLEN-1:0]   douta,
    input  logic [AW-1:0]     addrb,
    input  logic [XLEN-1:0]   dinb,
    input  logic [XLEN/8-1:0] web,
    output logic [XLEN-1:0]   doutb
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned WORDS = 32'd1 << AW;

    logic [XLEN-1:0] mem [WORDS];

    // Fetch read; a same-cycle port-B write to this word is not yet visible.
    always_ff @(posedge clk) begin
        if (ena) begin
            douta <= mem[addra];
        end
    end

    // Debug read-first with per-byte write enables.
    always_ff @(posedge clk) begin
        doutb <= mem[addrb];
        for (int b = 0; b < NB; b++) begin
            if (web[b]) begin
                mem[addrb][8*b +: 8] <= dinb[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF/ID boundary: instruction RAM plus a DEPTH-entry PC/instruction queue
// with valid/ready handshakes on both sides and a flush.
// Ports:
//   clk, rst                         clock, async active-high reset
//   fetch_valid, fetch_ready, pc_f   fetch request handshake and PC
//   flush                            squash queue and in-flight read
//   id_valid, id_ready, pc_d, instr_d  decode-side head handshake
//   a2, wd2, we2, rd2                debug RAM access (1-cycle read)
module if_id_fetch_queue #(
    parameter int unsigned XLEN  = cpu_pkg::XLEN,
    parameter int unsigned AW    = 12,
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid,
    output logic              fetch_ready,
    input  logic [XLEN-1:0]   pc_f,
    input  logic              flush,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [XLEN-1:0]   pc_d,
    output logic [XLEN-1:0]   instr_d,
    input  logic [XLEN-1:0]   a2,
    input  logic [XLEN-1:0]   wd2,
    input  logic [XLEN/8-1:0] we2,
    output logic [XLEN-1:0]   rd2
);

    import cpu_pkg::*;

    localparam int unsigned PW = clog2(DEPTH);
    localparam int unsigned CW = clog2(DEPTH + 1);
    localparam int unsigned OW = CW + 1;

    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] pc_inflight_q, pc_inflight_d;

    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [XLEN-1:0] q_instr [DEPTH];

    logic [XLEN-1:0] douta;
    logic [OW-1:0]   occ;
    logic            q_nonempty;
    logic            deq;
    logic            acc;
    logic            bypass_deq;
    logic            capture;

    logic            unused_addr_bits;
    assign unused_addr_bits = ^{pc_f[XLEN-1:AW+2], pc_f[1:0],
                                a2[XLEN-1:AW+2], a2[1:0]};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    instr_ram_dp #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_ram (
        .clk   (clk),
        .ena   (acc),
        .addra (pc_f[AW+1:2]),
        .douta (douta),
        .addrb (a2[AW+1:2]),
        .dinb  (wd2),
        .web   (we2),
        .doutb (rd2)
    );

    // Handshake: occupancy counts the read still in the RAM pipeline, and a
    // same-cycle consume frees a slot (id_ready feeds fetch_ready directly).
    always_comb begin
        q_nonempty  = (count_q != '0);
        id_valid    = q_nonempty || inflight_q;
        deq         = id_valid && id_ready;
        occ         = OW'(count_q) + OW'(inflight_q);
        fetch_ready = !flush && ((occ - OW'(deq)) < OW'(DEPTH));
        acc         = fetch_valid && fetch_ready;
        bypass_deq  = deq && !q_nonempty;
        capture     = inflight_q && !bypass_deq;
    end

    // Head select: queued entries are older than the returning RAM word.
    always_comb begin
        pc_d    = '0;
        instr_d = '0;
        if (q_nonempty) begin
            pc_d    = q_pc[rd_ptr_q];
            instr_d = q_instr[rd_ptr_q];
        end else if (inflight_q) begin
            pc_d    = pc_inflight_q;
            instr_d = douta;
        end
    end

    // Next-state for pointers, count and in-flight tracking.
    always_comb begin
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        inflight_d    = inflight_q;
        pc_inflight_d = pc_inflight_q;
        if (flush) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            inflight_d = 1'b0;
        end else begin
            count_d       = count_q + CW'(capture) - CW'(deq && q_nonempty);
            rd_ptr_d      = (deq && q_nonempty) ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            wr_ptr_d      = capture ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            inflight_d    = acc;
            pc_inflight_d = pc_f;
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            inflight_q    <= 1'b0;
            pc_inflight_q <= '0;
        end else begin
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            inflight_q    <= inflight_d;
            pc_inflight_q <= pc_inflight_d;
        end
    end

    // Queue storage: park the returning word when it is not consumed via bypass.
    always_ff @(posedge clk) begin
        if (capture && !flush) begin
            q_pc[wr_ptr_q]    <= pc_inflight_q;
            q_instr[wr_ptr_q] <= douta;
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
                                    count_q <= CW'(DEPTH));

endmodule
